// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 3-column x 4-row telephone keypad. One column is driven low at a
// time, the row returns are synchronised and sampled at the end of each
// column dwell, and every full frame (columns 0,1,2) is classified as no key,
// exactly one key, or several keys. A debounce FSM turns stable frames into a
// one-cycle key_valid strobe with a 4-bit key_code.
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat of
// key_valid while a key stays held (REPEAT_DELAY frames to the first repeat,
// then every REPEAT_RATE frames). Without the macro no repeat logic is built.
//
// Parameters
//   SCAN_DIV       clk cycles per column dwell (>= 4)
//   DEBOUNCE_SCANS identical frames needed to accept a press / release (>= 1)
//   REPEAT_DELAY   frames from acceptance to the first repeat (>= 1)
//   REPEAT_RATE    frames between later repeats (>= 1)
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   col_n[2:0] column drives, active-low, exactly one low
//   row_n[3:0] row returns, active-low, asynchronous to clk
//   key_code   code of the last accepted key (held until the next press)
//   key_valid  one-cycle strobe per accepted press (and per repeat)
//   key_down   high while the accepted key is held (debounced)
//   multi_key  high if the latest frame saw more than one key
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       multi_key
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Out-of-range parameters leave this marker block in the elaborated tree.
    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    end

    // Number of keys set in a frame (only the 12 real key positions count).
    function automatic logic [3:0] count_keys(input logic [15:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 12; i++) begin
            n = n + {3'b000, k[i]};
        end
        return n;
    endfunction

    // Position (row*3 + col) of the lowest set key.
    function automatic logic [3:0] first_key(input logic [15:0] k);
        logic [3:0] idx;
        idx = '0;
        for (int i = 11; i >= 0; i--) begin
            if (k[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Key position to telephone key code; bottom row is '*', '0', '#'.
    function automatic logic [3:0] code_of(input logic [3:0] idx);
        logic [3:0] c;
        case (idx)
            4'd9:    c = 4'hE;
            4'd10:   c = 4'h0;
            4'd11:   c = 4'hF;
            default: c = idx + 4'd1;
        endcase
        return c;
    endfunction

    // Debounce counter increment, saturating at DEBOUNCE_SCANS.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    logic [3:0]       row_p0;
    logic [3:0]       row_p1;
    logic [DIV_W-1:0] div;
    logic [1:0]       col;
    logic [3:0]       hit_c0;
    logic [3:0]       hit_c1;
    logic [1:0]       state;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;

    logic             sample_now;
    logic             frame_eval;
    logic [3:0]       hit_now;
    logic [15:0]      keys;
    logic [3:0]       n_keys;
    logic             single;
    logic [3:0]       key_idx;
    logic             cand_held;
    logic [CNT_W-1:0] cnt_inc;
    logic             rpt_fire;

    // ---- stage p0/p1: row synchroniser, divider and column sequencer ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_p0 <= 4'hF;
            row_p1 <= 4'hF;
            div    <= '0;
            col    <= 2'd0;
        end else begin
            row_p0 <= row_n;
            row_p1 <= row_p0;
            if (sample_now) begin
                div <= '0;
                col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    always_comb begin
        case (col)
            2'd0:    col_n = 3'b110;
            2'd1:    col_n = 3'b101;
            default: col_n = 3'b011;
        endcase
    end

    // Column 0/1 samples are always rewritten before the next column-2
    // evaluation, so they need no reset.
    always_ff @(posedge clk) begin
        if (sample_now && col == 2'd0) hit_c0 <= ~row_p1;
        if (sample_now && col == 2'd1) hit_c1 <= ~row_p1;
    end

    // ---- frame classification (column-2 sample cycle) ----
    always_comb begin
        sample_now = (div == DIV_LAST);
        frame_eval = sample_now && (col == 2'd2);
        hit_now    = ~row_p1;
        keys       = '0;
        for (int r = 0; r < 4; r++) begin
            keys[r*3 + 0] = hit_c0[r];
            keys[r*3 + 1] = hit_c1[r];
            keys[r*3 + 2] = hit_now[r];
        end
        n_keys    = count_keys(keys);
        single    = (n_keys == 4'd1);
        key_idx   = first_key(keys);
        cand_held = keys[cand];
        cnt_inc   = sat_inc(cnt);
    end

    // ---- debounce FSM and outputs (registered, one cycle after evaluation) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_eval) begin
                multi_key <= (n_keys > 4'd1);
                case (state)
                    ST_IDLE: begin
                        if (single) begin
                            cand <= key_idx;
                            cnt  <= CNT_ONE;
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= ST_PRESSED;
                                key_code  <= code_of(key_idx);
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (single && key_idx == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_MAX) begin
                                state     <= ST_PRESSED;
                                key_code  <= code_of(cand);
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        // Extra keys alongside the held one are ignored.
                        if (cand_held) begin
                            key_valid <= rpt_fire;
                        end else if (DEBOUNCE_SCANS == 1) begin
                            state    <= ST_IDLE;
                            key_down <= 1'b0;
                        end else begin
                            cnt   <= CNT_ONE;
                            state <= ST_RELEASE;
                        end
                    end
                    default: begin
                        if (cand_held) begin
                            state <= ST_PRESSED;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_MAX) begin
                                state    <= ST_IDLE;
                                key_down <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic [RPT_W-1:0] rpt_inc;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_hold;

    // Counts held frames toward the next repeat; the first target is the
    // initial delay, later targets are the repeat rate.
    always_comb begin
        rpt_hold   = frame_eval && (state == ST_PRESSED) && cand_held;
        rpt_inc    = rpt_cnt + RPT_W'(1);
        rpt_target = rpt_first ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
        rpt_fire   = rpt_hold && (rpt_inc == rpt_target);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (frame_eval) begin
            if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end else if (rpt_hold) begin
                rpt_cnt <= rpt_inc;
            end else begin
                // Any frame outside a held PRESSED frame restarts the delay.
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 3-column × 4-row telephone keypad on the board's key header. Drives one column low at a time, debounces the row returns, and emits a 4-bit key code with a one-cycle strobe. The code feeds the seven-segment encoder and the click summator. It is the input-side counterpart of the display path: it produces the digit that the encoder consumes.

## Interface
- SCAN_DIV, 50000: clk cycles each column is driven (1 ms at 50 MHz); must be ≥ 4.
- DEBOUNCE_SCANS, 20: consecutive identical full scan frames required to accept a press or a release; must be ≥ 1.
- REPEAT_DELAY, 500: frames held before the first auto-repeat (used only with KEYPAD_REPEAT_EN).
- REPEAT_RATE, 100: frames between auto-repeats (used only with KEYPAD_REPEAT_EN).
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- col_n  output  3  column drives; active-low, exactly one bit low at any time.
- row_n  input  4  row returns; active-low, asynchronous to clk.
- key_code  output  4  code of the accepted key; holds until the next accepted press.
- key_valid  output  1  one-cycle strobe when a press is accepted.
- key_down  output  1  level; high while the accepted key is held (debounced).
- multi_key  output  1  level; high if the most recent frame saw more than one key.

## Operation
- row_n passes through a 2-flop synchronizer before any use.
- The divider counts 0..SCAN_DIV-1. On count SCAN_DIV-1, the synchronized rows for the active column are sampled. On the following cycle the column advances 0→1→2→0 (col_n 110→101→011→110).
- A frame is the set of samples for columns 0, 1 and 2. It is evaluated on the column-2 sample cycle and classified as NONE, SINGLE(code) or MULTI.
- Code map (row r, col c): r0: 1,2,3; r1: 4,5,6; r2: 7,8,9; r3: '*'=4'hE, '0'=4'h0, '#'=4'hF.
- multi_key is updated on every frame evaluation.
- FSM is evaluated only at frame evaluation:
  - IDLE:
    - SINGLE(k): cand←k, cnt←1, go to DEBOUNCE. With DEBOUNCE_SCANS=1, go directly to PRESSED.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED, latch key_code←cand, pulse key_valid, set key_down←1.
    - Any other frame: go to IDLE.
  - PRESSED:
    - Frame contains cand (alone or with others): stay.
    - Otherwise: cnt←1, go to RELEASE. With DEBOUNCE_SCANS=1, go to IDLE instead.
  - RELEASE:
    - Frame contains cand: go to PRESSED, no new strobe.
    - Otherwise: cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE and set key_down←0.
- A key pressed while another is held is never reported. It must be re-pressed after release and debounced from IDLE.
- cnt saturates at DEBOUNCE_SCANS; its width is clog2(DEBOUNCE_SCANS+1).

## Timing
- Reset values:
  - col_n=3'b110
  - key_code=4'h0, key_valid=0, key_down=0, multi_key=0
  - FSM=IDLE, divider=0, synchronizer flops=1.
- Asynchronous reset takes effect immediately in any state, including mid-DEBOUNCE and mid-RELEASE. Scanning restarts at column 0 with a full SCAN_DIV dwell after rst deasserts.
- Row-to-sample latency is 2 cycles (synchronizer). Each column is stable for SCAN_DIV-2 cycles before it is sampled.
- One frame = 3×SCAN_DIV cycles.
- key_valid, key_code and key_down change on the cycle after the accepting frame evaluation. key_valid is high for exactly one cycle.
- key_down falls on the cycle after the DEBOUNCE_SCANS-th empty-of-cand frame.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a frame counter counts held frames.
  - At REPEAT_DELAY frames after acceptance, key_valid pulses again with the same key_code.
  - It then pulses every REPEAT_RATE frames while in PRESSED.
  - The counter clears on leaving PRESSED; returning from RELEASE restarts the delay.
- KEYPAD_REPEAT_EN undefined:
  - Exactly one key_valid per accepted press.
  - REPEAT_* parameters are ignored and no repeat counter is synthesized.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, so one frame = 12 cycles.

- Reset: assert rst mid-scan → col_n=110 and all outputs 0 in the same cycle; col_n first changes to 101 exactly 4 cycles after rst deasserts.
- Press '5' (row1/col1) for 6 frames, then release → exactly one key_valid with key_code=4'h5. key_down rises at the end of frame 3 and falls 3 empty frames after release.
- Bounce on '#': held 2 frames, open 1, held 4 → no strobe for the first burst; one strobe with key_code=4'hF after the 3rd consecutive held frame.
- '1' and '2' pressed together from IDLE for 5 frames → multi_key=1, no key_valid, key_code stays 0. Then release '2' → '1' accepted after 3 frames.
- Hold '7' and add '9' for 4 frames → key_code stays 7, no new strobe. Release '7' while '9' stays held → key_down falls after 3 frames and '9' is accepted 3 frames later.
- KEYPAD_REPEAT_EN with REPEAT_DELAY=4 and REPEAT_RATE=2; hold '0' for 12 frames → strobes at acceptance, +4, +6, +8 frames after acceptance, all with key_code=4'h0.
